// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
package reg_wb_ctrl_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Producer handshakes, register-file write port and hazard mask of reg_wb_ctrl.
interface reg_wb_ctrl_if;
  import reg_wb_ctrl_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_addr;
  logic [XLEN-1:0]       lsu_data;
  logic                  wrEn;
  logic [REG_ADDR_W-1:0] wrAddr;
  logic [XLEN-1:0]       wrData;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    input  alu_ready, lsu_ready, wrEn, wrAddr, wrData, busy_mask
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    output alu_ready, lsu_ready, wrEn, wrAddr, wrData, busy_mask
  );
endinterface

// File: rtl/reg_wb_ctrl_fifo.sv
// Per-source writeback FIFO with per-entry address match and pending-register vector.
module wb_fifo
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [REG_ADDR_W-1:0]   match_addr,
  output logic [DEPTH-1:0]        match_vec,
  output logic [NUM_REGS-1:0]     busy_vec
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [DEPTH-1:0] entry_valid;
  logic             do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid = '0;
    match_vec   = '0;
    busy_vec    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[PW'(i)] = ({1'b0, PW'(i) - rd_ptr} < count);
      match_vec[PW'(i)]   = entry_valid[PW'(i)] && (match_addr != '0) &&
                            (mem[PW'(i)].addr == match_addr);
      if (entry_valid[PW'(i)]) busy_vec = busy_vec | onehot(mem[PW'(i)].addr);
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Two-source writeback controller: buffers ALU/LSU results and arbitrates them onto the register-file write port.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  reg_wb_ctrl_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PW:0]   CNT_MAX    = (PW+1)'(DEPTH);

  wb_entry_t             alu_head, lsu_head, grant_entry;
  logic                  alu_full, alu_empty, lsu_full, lsu_empty;
  logic [PW:0]           alu_count, lsu_count;
  logic [DEPTH-1:0]      alu_match, lsu_match;
  logic [NUM_REGS-1:0]   alu_busy, lsu_busy, wr_busy;
  logic                  alu_rdy, lsu_rdy, alu_push, lsu_push, alu_pop, lsu_pop;
  logic                  grant_any;
  src_e                  grant_src;
  logic [SW-1:0]         starve_cnt;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;

  // Each FIFO matches against the other source's incoming address.
  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .push(alu_push),
    .push_entry('{addr: bus.alu_addr, data: bus.alu_data}),
    .pop(alu_pop), .head(alu_head), .full(alu_full), .empty(alu_empty),
    .count(alu_count), .match_addr(bus.lsu_addr), .match_vec(alu_match),
    .busy_vec(alu_busy)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk(clk), .rst(rst), .push(lsu_push),
    .push_entry('{addr: bus.lsu_addr, data: bus.lsu_data}),
    .pop(lsu_pop), .head(lsu_head), .full(lsu_full), .empty(lsu_empty),
    .count(lsu_count), .match_addr(bus.alu_addr), .match_vec(lsu_match),
    .busy_vec(lsu_busy)
  );

  // A source is held off while the other one still owns a write to the same register.
  assign alu_rdy  = !alu_full && !(|lsu_match);
  assign lsu_rdy  = !lsu_full && !(|alu_match) &&
                    !(bus.alu_valid && alu_rdy && (bus.alu_addr == bus.lsu_addr) &&
                      (bus.lsu_addr != '0));
  assign alu_push = bus.alu_valid && alu_rdy && (bus.alu_addr != '0);
  assign lsu_push = bus.lsu_valid && lsu_rdy && (bus.lsu_addr != '0);

  always_comb begin
    grant_any   = !alu_empty || !lsu_empty;
    grant_src   = SRC_ALU;
    if (!lsu_empty && (alu_empty || starve_cnt == STARVE_MAX)) grant_src = SRC_LSU;
    alu_pop     = grant_any && (grant_src == SRC_ALU);
    lsu_pop     = grant_any && (grant_src == SRC_LSU);
    grant_entry = (grant_src == SRC_LSU) ? lsu_head : alu_head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (lsu_empty || lsu_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= grant_any;
      if (grant_any) begin
        wr_addr <= grant_entry.addr;
        wr_data <= grant_entry.data;
      end
    end
  end

  assign wr_busy       = wr_en ? onehot(wr_addr) : '0;
  assign bus.alu_ready = alu_rdy;
  assign bus.lsu_ready = lsu_rdy;
  assign bus.wrEn      = wr_en;
  assign bus.wrAddr    = wr_addr;
  assign bus.wrData    = wr_data;
  assign bus.busy_mask = (alu_busy | lsu_busy | wr_busy) & {{(NUM_REGS-1){1'b1}}, 1'b0};

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    (alu_count <= CNT_MAX) && (lsu_count <= CNT_MAX));

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl: directed ALU/LSU traffic, expected writes checked in order.
module tb_reg_wb_ctrl;
  import reg_wb_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  wb_entry_t exp_q[$];

  reg_wb_ctrl_if bus();

  reg_wb_ctrl #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Monitor: every cycle with wrEn high must retire the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.wrEn) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write (t=%0t)",
                 bus.wrAddr, bus.wrData, $time);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wrAddr), 32'(e.addr));
        chk("wr_data", bus.wrData, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input src_e src, input logic v, input logic [4:0] a, input logic [31:0] d);
    if (src == SRC_ALU) begin
      bus.alu_valid = v; bus.alu_addr = a; bus.alu_data = d;
    end else begin
      bus.lsu_valid = v; bus.lsu_addr = a; bus.lsu_data = d;
    end
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input src_e src, input logic [4:0] a, input logic [31:0] d, output int waits);
    bit done;
    waits = 0;
    done  = 1'b0;
    drive(src, 1'b1, a, d);
    while (!done) begin
      @(negedge clk);
      if ((src == SRC_ALU) ? bus.alu_ready : bus.lsu_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else if (waits >= 20) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: got no ready after %0d cycles expected ready (src=%0d x%0d)",
                 waits, src, a);
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    #1;
    drive(src, 1'b0, a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, w1;
    drive(SRC_ALU, 1'b0, '0, '0);
    drive(SRC_LSU, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wren", 32'(bus.wrEn), 32'd0);
    chk("rst_wraddr", 32'(bus.wrAddr), 32'd0);
    chk("rst_wrdata", bus.wrData, 32'd0);
    chk("rst_busy", bus.busy_mask, 32'd0);
    chk("rst_ready", {30'd0, bus.alu_ready, bus.lsu_ready}, 32'd3);
    step();

    // Reset mid-operation: queued x1/x2 must be discarded, never written.
    fork
      send(SRC_ALU, 5'd1, 32'h0000_0101, w0);
      send(SRC_LSU, 5'd2, 32'h0000_0202, w1);
    join
    chk("pre_rst_busy", bus.busy_mask, 32'h0000_0006);
    rst = 1'b1;
    #1;
    chk("in_rst_wren", 32'(bus.wrEn), 32'd0);
    chk("in_rst_busy", bus.busy_mask, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {30'd0, bus.alu_ready, bus.lsu_ready}, 32'd3);
    repeat (3) step();
    chk("post_rst_wren", 32'(bus.wrEn), 32'd0);
    chk("post_rst_busy", bus.busy_mask, 32'd0);

    // Single ALU write: busy for the FIFO cycle and the write cycle only.
    expect_wr(5'd5, 32'hDEAD_BEEF);
    send(SRC_ALU, 5'd5, 32'hDEAD_BEEF, w0);
    chk("single_wait", 32'(w0), 32'd0);
    chk("single_busy_n", bus.busy_mask, 32'h0000_0020);
    chk("single_wren_n", 32'(bus.wrEn), 32'd0);
    step();
    chk("single_wren_n1", 32'(bus.wrEn), 32'd1);
    chk("single_busy_n1", bus.busy_mask, 32'h0000_0020);
    step();
    chk("single_wren_n2", 32'(bus.wrEn), 32'd0);
    chk("single_busy_n2", bus.busy_mask, 32'd0);

    // x0 writes are accepted and dropped.
    send(SRC_ALU, 5'd0, 32'h0000_1234, w0);
    chk("x0_wait", 32'(w0), 32'd0);
    chk("x0_busy", bus.busy_mask, 32'd0);
    step();
    chk("x0_wren", 32'(bus.wrEn), 32'd0);
    chk("x0_busy2", bus.busy_mask, 32'd0);
    repeat (2) step();

    // Starvation: LSU x9 loses three arbitrations, wins the fourth.
    for (int i = 1; i <= 3; i++) expect_wr(5'(i), 32'hA000_0000 + 32'(i));
    expect_wr(5'd9, 32'h0000_00AA);
    for (int i = 4; i <= 8; i++) expect_wr(5'(i), 32'hA000_0000 + 32'(i));
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          send(SRC_ALU, 5'(i), 32'hA000_0000 + 32'(i), w0);
          chk("starve_alu_wait", 32'(w0), 32'd0);
        end
      end
      begin
        send(SRC_LSU, 5'd9, 32'h0000_00AA, w1);
        chk("starve_lsu_wait", 32'(w1), 32'd0);
      end
    join
    repeat (8) step();
    chk("starve_drained", 32'(exp_q.size()), 32'd0);

    // Cross-source ordering on x7: ALU waits until the LSU entry has left its FIFO.
    expect_wr(5'd1, 32'h0000_0001);
    expect_wr(5'd7, 32'h0000_0011);
    expect_wr(5'd7, 32'h0000_0022);
    fork
      begin
        send(SRC_ALU, 5'd1, 32'h0000_0001, w0);
        send(SRC_ALU, 5'd7, 32'h0000_0022, w0);
        chk("xsrc_alu_blocked", 32'(w0), 32'd2);
      end
      send(SRC_LSU, 5'd7, 32'h0000_0011, w1);
    join
    repeat (6) step();
    chk("xsrc_drained", 32'(exp_q.size()), 32'd0);

    // Full LSU FIFO: 5th entry waits one cycle; interleave set by the starvation limit.
    for (int i = 1; i <= 3; i++) expect_wr(5'(i), 32'hB000_0000 + 32'(i));
    expect_wr(5'd16, 32'hC000_0010);
    for (int i = 4; i <= 6; i++) expect_wr(5'(i), 32'hB000_0000 + 32'(i));
    for (int i = 17; i <= 20; i++) expect_wr(5'(i), 32'hC000_0000 + 32'(i));
    fork
      begin
        for (int i = 1; i <= 6; i++) send(SRC_ALU, 5'(i), 32'hB000_0000 + 32'(i), w0);
      end
      begin
        for (int i = 16; i <= 20; i++) begin
          send(SRC_LSU, 5'(i), 32'hC000_0000 + 32'(i), w1);
          chk("full_lsu_wait", 32'(w1), (i == 20) ? 32'd1 : 32'd0);
        end
      end
    join
    repeat (12) step();
    chk("full_drained", 32'(exp_q.size()), 32'd0);
    chk("final_busy", bus.busy_mask, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Write-side controller for the 32x32 register file. Collects writeback results from two producers, the ALU and the load/store unit (LSU), over valid/ready handshakes.
- Buffers results in per-source FIFOs and arbitrates them onto the register file's single write port (wrEn/wrAddr/wrData).
- Publishes a pending-write mask so decode can stall on RAW/WAW hazards.

Parameters:
- DEPTH, 4, entries per source FIFO (power of 2, >=2)
- STARVE_LIMIT, 3, consecutive lost arbitrations before the LSU head is forced to win

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result valid
- alu_ready  output  1  ALU result accepted this cycle when valid&ready
- alu_addr  input  5  ALU destination register
- alu_data  input  32  ALU result
- lsu_valid  input  1  LSU result valid
- lsu_ready  output  1  LSU result accepted when valid&ready
- lsu_addr  input  5  LSU destination register
- lsu_data  input  32  LSU load data
- wrEn  output  1  register-file write enable (registered)
- wrAddr  output  5  register-file write address (registered)
- wrData  output  32  register-file write data (registered)
- busy_mask  output  32  bit i=1 while a write to register i is pending anywhere in the block

Behaviour:
- Reset (async, rst=1):
  - Both FIFOs are emptied and the starvation counter is cleared.
  - wrEn=0, wrAddr=0, wrData=0, busy_mask=0.
  - alu_ready and lsu_ready go to 1 once rst is released.
  - Entries in flight are discarded, not written.
- Acceptance: a source transfer happens on a posedge where valid&ready=1.
  - A transfer with addr=0 is accepted and dropped. It does not enter the FIFO and never sets busy_mask.
- Ready rules (combinational), for each source X, with Y the other source:
  - X_ready=1 iff X's FIFO is not full, AND
  - X_addr (if nonzero) does not match any valid entry in Y's FIFO, AND
  - (for the LSU only) NOT (alu_valid & alu_ready & alu_addr==lsu_addr & lsu_addr!=0).
  - This prevents cross-source reordering of writes to the same register; same-cycle ties go to the ALU.
  - Each FIFO preserves its own order.
- Arbitration (each cycle, over the FIFO heads):
  - If only one head is valid, that head is granted.
  - If both are valid, the ALU is granted, unless starve_cnt==STARVE_LIMIT, in which case the LSU is granted.
  - starve_cnt increments (saturating) each cycle the LSU head is valid and not granted. It clears on an LSU grant or when the LSU FIFO is empty.
- Output register:
  - On the posedge after a grant, wrEn=1 and wrAddr/wrData take the granted entry, which is popped.
  - With no grant, wrEn=0 and wrAddr/wrData hold their values.
  - The register file captures the write on the following posedge.
- Latency:
  - Transfer at edge N -> wrEn=1 during cycle N+1 (from edge N+1), register written at edge N+2, at the earliest.
  - Throughput is 1 write/cycle aggregate.
- busy_mask: OR over valid FIFO entries and (wrEn ? onehot(wrAddr) : 0). Bit 0 is always 0.
  - The bit for an entry rises the cycle after acceptance.
  - It falls after the output register has retired the entry, provided no other entry holds the same address.
- FIFO boundaries:
  - Full: ready=0; valid may be held.
  - Simultaneous push and pop on a full FIFO is not permitted, because ready is based on the pre-pop count.
  - Pointers wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package/header: constant NUM_REGS=32, REG_ADDR_W=5, XLEN=32; source-select encodings SRC_ALU=0, SRC_LSU=1.
- Sub-module: wb_fifo (parameterised DEPTH x 37-bit sync FIFO with async reset, push/pop/full/empty/count, plus a per-entry address match output for the ready and busy logic). Instantiated twice.

Test Plan:
- Reset mid-operation: fill ALU FIFO with x1..x3, assert rst for 1 cycle -> wrEn=0, busy_mask=0, no writes to x1..x3 ever observed.
- Single ALU write: alu x5=0xDEADBEEF accepted at edge N -> wrEn=1, wrAddr=5, wrData=0xDEADBEEF at edge N+1; busy_mask[5] high from N+1 through N+1 cycle only.
- x0 drop: alu_addr=0, data=0x1234 -> alu_ready=1, accepted, wrEn stays 0, busy_mask stays 0.
- Starvation: ALU valid every cycle to x1..x8, LSU single x9=0xAA -> LSU granted after exactly 3 lost cycles (4th arbitration), then ALU resumes.
- Cross-source ordering: LSU x7=0x11 pending in FIFO, ALU presents x7=0x22 -> alu_ready=0 until the LSU entry is popped; final writes in order 0x11 then 0x22.
- Full FIFO: hold wrEn path busy with ALU, push 4 LSU entries -> lsu_ready=0 on the 5th; after drain, all 4 written in order with correct data.
